// File: rtl/data_mem_unit.sv
// Registered data memory for the MEM stage: RISC-V load/store widths,
// sign/zero extension, fault detection and a programmable wait-state count.
module data_mem_unit #(
    parameter int XLEN        = 64,
    parameter int DEPTH_BYTES = 4096,
    parameter int WAIT_CYCLES = 0
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic            req_write,
    input  logic [2:0]      funct3,
    input  logic [XLEN-1:0] addr,
    input  logic [XLEN-1:0] wdata,
    output logic            resp_valid,
    output logic [XLEN-1:0] rdata,
    output logic            fault
);

    localparam int AW = $clog2(DEPTH_BYTES);
    localparam int NB = XLEN / 8;
    localparam logic [3:0] CNT_INIT =
        (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        RESP
    } state_t;

    state_t          state_q, state_d;
    logic [3:0]      cnt_q, cnt_d;
    logic            write_q, write_d;
    logic [2:0]      f3_q, f3_d;
    logic [XLEN-1:0] addr_q, addr_d;
    logic [XLEN-1:0] wdata_q, wdata_d;
    logic [XLEN-1:0] rdata_q, rdata_d;
    logic            fault_q, fault_d;

    logic [7:0]      mem [DEPTH_BYTES];

    logic            accept;
    logic            commit;
    logic            mem_we;

    logic            c_write;
    logic [2:0]      c_f3;
    logic [XLEN-1:0] c_addr;
    logic [XLEN-1:0] c_wdata;
    logic [3:0]      c_size;
    logic [2:0]      c_mask;
    logic [AW-1:0]   c_idx;
    logic [XLEN:0]   c_end;
    logic            c_illegal;
    logic            c_misalign;
    logic            c_oob;
    logic            c_fault;
    logic [XLEN-1:0] raw;
    logic [XLEN-1:0] ld_val;

    assign req_ready  = (state_q == IDLE) && !rst;
    assign accept     = req_valid && req_ready;
    assign resp_valid = (state_q == RESP);
    assign rdata      = rdata_q;
    assign fault      = fault_q;

    // In IDLE the live request commits directly; in WAIT the latched one does.
    always_comb begin
        c_write = write_q;
        c_f3    = f3_q;
        c_addr  = addr_q;
        c_wdata = wdata_q;
        if (state_q == IDLE) begin
            c_write = req_write;
            c_f3    = funct3;
            c_addr  = addr;
            c_wdata = wdata;
        end
    end

    assign c_size = 4'd1 << c_f3[1:0];
    assign c_mask = 3'(c_size - 4'd1);
    assign c_idx  = c_addr[AW-1:0];
    assign c_end  = {1'b0, c_addr} + (XLEN+1)'(c_size);

    always_comb begin
        c_illegal = 1'b0;
        if (c_write) begin
            c_illegal = c_f3[2];
        end else begin
            c_illegal = (c_f3 == 3'b111);
        end
        if (XLEN == 32) begin
            if (c_f3[1:0] == 2'b11) c_illegal = 1'b1;
            if (!c_write && c_f3 == 3'b110) c_illegal = 1'b1;
        end
    end

    assign c_misalign = (c_addr[2:0] & c_mask) != 3'd0;
    assign c_oob      = c_end > (XLEN+1)'(DEPTH_BYTES);
    assign c_fault    = c_illegal || c_misalign || c_oob;

    always_comb begin
        raw = '0;
        for (int k = 0; k < NB; k++) begin
            if (4'(k) < c_size) begin
                raw[8*k +: 8] = mem[c_idx + AW'(k)];
            end
        end
    end

    // raw already has unused upper bytes cleared, so zero-extension is free.
    always_comb begin
        ld_val = raw;
        unique case (c_f3)
            3'b000: if (raw[7])  ld_val = raw | ({XLEN{1'b1}} << 8);
            3'b001: if (raw[15]) ld_val = raw | ({XLEN{1'b1}} << 16);
            3'b010: if (raw[31]) ld_val = raw | ({XLEN{1'b1}} << 32);
            default: ld_val = raw;
        endcase
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        write_d = write_q;
        f3_d    = f3_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        fault_d = fault_q;
        commit  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    write_d = req_write;
                    f3_d    = funct3;
                    addr_d  = addr;
                    wdata_d = wdata;
                    if (c_fault) begin
                        state_d = RESP;
                        rdata_d = '0;
                        fault_d = 1'b1;
                    end else if (WAIT_CYCLES == 0) begin
                        state_d = RESP;
                        commit  = 1'b1;
                    end else begin
                        state_d = WAIT;
                        cnt_d   = CNT_INIT;
                    end
                end
            end
            WAIT: begin
                if (cnt_q == 4'd0) begin
                    state_d = RESP;
                    commit  = 1'b1;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        if (commit) begin
            fault_d = 1'b0;
            rdata_d = c_write ? '0 : ld_val;
        end
    end

    assign mem_we = commit && c_write && !rst;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            write_q <= 1'b0;
            f3_q    <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            fault_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            write_q <= write_d;
            f3_q    <= f3_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            fault_q <= fault_d;
        end
    end

    // Storage is deliberately not reset.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            for (int k = 0; k < NB; k++) begin
                if (4'(k) < c_size) begin
                    mem[c_idx + AW'(k)] <= c_wdata[8*k +: 8];
                end
            end
        end
    end

endmodule

// File: tb/tb_data_mem_unit.sv
// Directed bench for data_mem_unit: one zero-wait and one three-wait
// instance, with a queue of expected responses.
module tb_data_mem_unit;

    logic        clk = 1'b0;
    logic        rst0, rst1;
    logic        rv0, rv1;
    logic        rdy0, rdy1;
    logic        req_write;
    logic [2:0]  funct3;
    logic [63:0] addr;
    logic [63:0] wdata;
    logic        rsp0, rsp1;
    logic [63:0] rd0, rd1;
    logic        flt0, flt1;

    typedef struct {
        logic [63:0] rd;
        logic        flt;
        int          lat;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   fails  = 0;

    always #5 clk = ~clk;

    data_mem_unit #(.XLEN(64), .DEPTH_BYTES(4096), .WAIT_CYCLES(0)) u0 (
        .clk(clk), .rst(rst0), .req_valid(rv0), .req_ready(rdy0),
        .req_write(req_write), .funct3(funct3), .addr(addr),
        .wdata(wdata), .resp_valid(rsp0), .rdata(rd0), .fault(flt0)
    );

    data_mem_unit #(.XLEN(64), .DEPTH_BYTES(4096), .WAIT_CYCLES(3)) u1 (
        .clk(clk), .rst(rst1), .req_valid(rv1), .req_ready(rdy1),
        .req_write(req_write), .funct3(funct3), .addr(addr),
        .wdata(wdata), .resp_valid(rsp1), .rdata(rd1), .fault(flt1)
    );

    function automatic logic rdy(input int u);
        return (u == 0) ? rdy0 : rdy1;
    endfunction

    function automatic logic rsp(input int u);
        return (u == 0) ? rsp0 : rsp1;
    endfunction

    function automatic logic [63:0] rdv(input int u);
        return (u == 0) ? rd0 : rd1;
    endfunction

    function automatic logic fltv(input int u);
        return (u == 0) ? flt0 : flt1;
    endfunction

    task automatic set_valid(input int u, input logic v);
        if (u == 0) rv0 = v;
        else rv1 = v;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic txn(input int u, input logic w, input logic [2:0] f,
                       input logic [63:0] a, input logic [63:0] d,
                       input logic [63:0] erd, input logic eflt,
                       input int elat, input bit pulse, input string tag);
        exp_t e;
        int   n;
        n = 0;
        while (!rdy(u) && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk({tag, " ready"}, 64'(rdy(u)), 64'd1);
        req_write = w;
        funct3    = f;
        addr      = a;
        wdata     = d;
        set_valid(u, 1'b1);
        sb.push_back('{erd, eflt, elat});
        @(negedge clk);
        set_valid(u, 1'b0);
        req_write = ~w;
        funct3    = 3'b111;
        addr      = '1;
        wdata     = '1;
        n = 1;
        while (!rsp(u) && n < 100) begin
            chk({tag, " busy"}, 64'(rdy(u)), 64'd0);
            if (pulse && n == 1) begin
                req_write = 1'b1;
                funct3    = 3'b011;
                addr      = a;
                wdata     = 64'hDEAD_DEAD_DEAD_DEAD;
                set_valid(u, 1'b1);
            end
            @(negedge clk);
            set_valid(u, 1'b0);
            n++;
        end
        chk({tag, " resp"}, 64'(rsp(u)), 64'd1);
        if (sb.size() > 0) begin
            e = sb.pop_front();
            chk({tag, " rdata"}, rdv(u), e.rd);
            chk({tag, " fault"}, 64'(fltv(u)), 64'(e.flt));
            chk({tag, " latency"}, 64'(n), 64'(e.lat));
        end
        chk({tag, " ready@resp"}, 64'(rdy(u)), 64'd0);
        @(negedge clk);
        chk({tag, " resp one-shot"}, 64'(rsp(u)), 64'd0);
        chk({tag, " ready after"}, 64'(rdy(u)), 64'd1);
    endtask

    initial begin
        logic seen;
        rst0 = 1'b1;
        rst1 = 1'b1;
        rv0 = 1'b0;
        rv1 = 1'b0;
        req_write = 1'b0;
        funct3 = '0;
        addr = '0;
        wdata = '0;
        @(posedge clk);
        @(negedge clk);
        chk("rst ready0", 64'(rdy0), 64'd0);
        chk("rst resp0", 64'(rsp0), 64'd0);
        chk("rst rdata0", rd0, 64'd0);
        chk("rst fault0", 64'(flt0), 64'd0);
        chk("rst ready1", 64'(rdy1), 64'd0);
        chk("rst rdata1", rd1, 64'd0);
        rst0 = 1'b0;
        rst1 = 1'b0;
        #1;
        chk("post-rst ready0", 64'(rdy0), 64'd1);
        @(negedge clk);

        txn(0, 1, 3'b011, 64'h10, 64'h8877665544332211, 0, 0, 1, 0, "sd");
        txn(0, 0, 3'b011, 64'h10, 0, 64'h8877665544332211, 0, 1, 0, "ld");
        txn(0, 0, 3'b000, 64'h10, 0, 64'h11, 0, 1, 0, "lb 0x10");
        txn(0, 0, 3'b000, 64'h17, 0, 64'hFFFFFFFFFFFFFF88, 0, 1, 0, "lb");
        txn(0, 0, 3'b100, 64'h17, 0, 64'h88, 0, 1, 0, "lbu");
        txn(0, 0, 3'b001, 64'h16, 0, 64'hFFFFFFFFFFFF8877, 0, 1, 0, "lh");
        txn(0, 0, 3'b101, 64'h16, 0, 64'h8877, 0, 1, 0, "lhu");
        txn(0, 0, 3'b110, 64'h14, 0, 64'h88776655, 0, 1, 0, "lwu");
        txn(0, 0, 3'b010, 64'h14, 0, 64'hFFFFFFFF88776655, 0, 1, 0, "lw");
        txn(0, 0, 3'b010, 64'h10, 0, 64'h44332211, 0, 1, 0, "lw pos");
        txn(0, 1, 3'b001, 64'h12, 64'h1234ABCD, 0, 0, 1, 0, "sh");
        txn(0, 0, 3'b011, 64'h10, 0, 64'h88776655ABCD2211, 0, 1, 0, "ld sh");

        txn(0, 0, 3'b010, 64'h0E, 0, 0, 1, 1, 0, "lw misalign");
        txn(0, 1, 3'b011, 64'hFFC, 64'h1, 0, 1, 1, 0, "sd oob");
        txn(0, 1, 3'b100, 64'h10, 64'h5, 0, 1, 1, 0, "store 100");
        txn(0, 1, 3'b001, 64'h11, 64'h5, 0, 1, 1, 0, "sh misalign");
        txn(0, 0, 3'b111, 64'h10, 0, 0, 1, 1, 0, "load 111");
        txn(0, 0, 3'b000, 64'h1000, 0, 0, 1, 1, 0, "lb oob");
        txn(0, 0, 3'b011, 64'h10, 0, 64'h88776655ABCD2211, 0, 1, 0,
            "ld unchanged");
        txn(0, 1, 3'b011, 64'hFF8, 64'h0102030405060708, 0, 0, 1, 0, "sd top");
        txn(0, 0, 3'b100, 64'hFFF, 0, 64'h01, 0, 1, 0, "lbu top");

        txn(1, 1, 3'b011, 64'h20, 64'h1122334455667788, 0, 0, 4, 0, "w3 sd");
        txn(1, 0, 3'b011, 64'h20, 0, 64'h1122334455667788, 0, 4, 1, "w3 ld");
        txn(1, 0, 3'b011, 64'h20, 0, 64'h1122334455667788, 0, 4, 0,
            "w3 ld no pulse");
        txn(1, 0, 3'b010, 64'h22, 0, 0, 1, 1, 0, "w3 fault");

        req_write = 1'b1;
        funct3 = 3'b011;
        addr = 64'h20;
        wdata = 64'hCAFEBABE00000000;
        rv1 = 1'b1;
        @(negedge clk);
        rv1 = 1'b0;
        chk("w3 pre-rst busy", 64'(rdy1), 64'd0);
        rst1 = 1'b1;
        #1;
        chk("mid-rst ready", 64'(rdy1), 64'd0);
        chk("mid-rst resp", 64'(rsp1), 64'd0);
        chk("mid-rst rdata", rd1, 64'd0);
        chk("mid-rst fault", 64'(flt1), 64'd0);
        @(negedge clk);
        @(negedge clk);
        rst1 = 1'b0;
        #1;
        chk("post mid-rst ready", 64'(rdy1), 64'd1);
        seen = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            seen = seen | rsp1;
        end
        chk("dropped resp", 64'(seen), 64'd0);
        txn(1, 0, 3'b011, 64'h20, 0, 64'h1122334455667788, 0, 4, 0,
            "w3 ld old");

        chk("scoreboard empty", 64'(sb.size()), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures",
                 checks, fails);
        $finish;
    end

endmodule
